// File: rtl/uart_rx_if.sv
// Serial receive bundle: the line into the receiver and the byte/status
// results coming back out of it.
interface uart_rx_if;
  logic       rx;
  logic       rx_busy;
  logic       rx_end;
  logic [7:0] rx_data;
  logic       rx_ferr;

  modport master (
    output rx,
    input  rx_busy,
    input  rx_end,
    input  rx_data,
    input  rx_ferr
  );

  modport slave (
    input  rx,
    output rx_busy,
    output rx_end,
    output rx_data,
    output rx_ferr
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: samples each bit at its centre using a DIV_RATE-cycle bit
// timer, and reports good frames (rx_end) or framing errors (rx_ferr).
module uart_rx #(
  parameter int unsigned DIV_RATE = 434
) (
  input  logic      clk,
  input  logic      reset,
  uart_rx_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_e;

  localparam logic [15:0] HALF_BIT = 16'(DIV_RATE / 2 - 1);
  localparam logic [15:0] FULL_BIT = 16'(DIV_RATE - 1);

  logic       sync1_q, sync1_d;
  logic       sync2_q, sync2_d;
  state_e     state_q, state_d;
  logic [15:0] timer_q, timer_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] data_q, data_d;
  logic       end_q, end_d;
  logic       ferr_q, ferr_d;
  logic       busy_q, busy_d;

  logic rx_s;
  logic full_hit;

  assign rx_s     = sync2_q;
  assign full_hit = (timer_q == FULL_BIT);

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    sync1_d   = bus.rx;
    sync2_d   = sync1_q;
    state_d   = state_q;
    timer_d   = timer_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    data_d    = data_q;
    end_d     = 1'b0;
    ferr_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          timer_d = '0;
        end
      end

      // A low level still present at half a bit time is a real start bit;
      // anything shorter is a glitch and is dropped silently.
      START: begin
        if (timer_q == HALF_BIT) begin
          if (!rx_s) begin
            state_d   = DATA;
            timer_d   = '0;
            bit_cnt_d = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end

      DATA: begin
        if (full_hit) begin
          shift_d   = {rx_s, shift_q[7:1]};
          timer_d   = '0;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = STOP;
          end
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end

      STOP: begin
        if (full_hit) begin
          timer_d = '0;
          if (rx_s) begin
            data_d  = shift_q;
            end_d   = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = WAIT_HIGH;
          end
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end

      // A break keeps the line low; wait for it to rise so it yields one error.
      WAIT_HIGH: begin
        if (rx_s) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      state_q   <= IDLE;
      timer_q   <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      end_q     <= 1'b0;
      ferr_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      end_q     <= end_d;
      ferr_q    <= ferr_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.rx_busy = busy_q;
  assign bus.rx_end  = end_q;
  assign bus.rx_data = data_q;
  assign bus.rx_ferr = ferr_q;

  a_end_ferr_exclusive: assert property (@(posedge clk) disable iff (reset)
    !(end_q && ferr_q));

  a_end_not_busy: assert property (@(posedge clk) disable iff (reset)
    end_q |-> !busy_q);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at DIV_RATE=16: frames are serialised bit by bit,
// the expected outcome of each is queued and a monitor compares every pulse.
module tb_uart_rx;

  localparam int DIV = 16;

  logic clk;
  logic reset;
  uart_rx_if bus ();

  uart_rx #(.DIV_RATE(DIV)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         is_end;
    logic [7:0] data;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] model_data;
  int         checks;
  int         errors;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic idle(input int n);
    bus.rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input logic v);
    bus.rx = v;
    repeat (DIV) @(negedge clk);
  endtask

  // Reference: a good stop bit delivers the byte; a low stop bit reports an
  // error and the last good byte stays on the output.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok);
    exp_t e;
    e.is_end = stop_ok;
    if (stop_ok) model_data = b;
    e.data = model_data;
    exp_q.push_back(e);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_ok);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("queue_drained", exp_q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (!reset && (bus.rx_end || bus.rx_ferr)) begin
      exp_t e;
      check("end_ferr_exclusive", {31'd0, bus.rx_end & bus.rx_ferr}, 0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: end=%0b ferr=%0b data=0x%0h, expected none at %0t",
                 bus.rx_end, bus.rx_ferr, bus.rx_data, $time);
      end else begin
        e = exp_q.pop_front();
        check("pulse_kind_is_end", {31'd0, bus.rx_end}, {31'd0, e.is_end});
        check("rx_data", {24'd0, bus.rx_data}, {24'd0, e.data});
        if (bus.rx_end) check("busy_in_end_cycle", {31'd0, bus.rx_busy}, 0);
      end
    end
  end

  initial begin
    int busy_cnt;
    int n;
    bit ok;
    logic [7:0] b;
    logic [7:0] v;

    checks     = 0;
    errors     = 0;
    model_data = 8'h00;
    reset      = 1'b1;
    bus.rx     = 1'b1;
    repeat (5) @(negedge clk);
    check("reset_busy", {31'd0, bus.rx_busy}, 0);
    check("reset_end",  {31'd0, bus.rx_end}, 0);
    check("reset_ferr", {31'd0, bus.rx_ferr}, 0);
    check("reset_data", {24'd0, bus.rx_data}, 0);
    reset = 1'b0;
    idle(5);

    // Single good frame
    send_frame(8'h55, 1'b1);
    idle(4);
    drain();
    check("busy_after_frame", {31'd0, bus.rx_busy}, 0);

    // Short glitch on an idle line
    busy_cnt = 0;
    bus.rx = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (i == 4) bus.rx = 1'b1;
      @(negedge clk);
      if (bus.rx_busy) busy_cnt++;
    end
    ok = (busy_cnt >= 1) && (busy_cnt <= 11);
    check("glitch_busy_window", {31'd0, ok}, 1);
    check("glitch_data_kept", {24'd0, bus.rx_data}, 8'h55);

    // Framing error, prior byte retained
    send_frame(8'hA3, 1'b0);
    idle(8);
    drain();
    check("ferr_data_kept", {24'd0, bus.rx_data}, 8'h55);
    check("ferr_back_to_idle", {31'd0, bus.rx_busy}, 0);

    // Back-to-back frames
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h81, 1'b1);
    idle(8);
    drain();

    // Reset in the middle of bit 4 of 0x3C
    v = 8'h3C;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(v[i]);
    bus.rx = v[4];
    repeat (8) @(negedge clk);
    reset = 1'b1;
    model_data = 8'h00;
    repeat (2) @(negedge clk);
    check("midframe_reset_data", {24'd0, bus.rx_data}, 0);
    check("midframe_reset_busy", {31'd0, bus.rx_busy}, 0);
    reset = 1'b0;
    idle(40);
    send_frame(8'hC3, 1'b1);
    idle(4);
    drain();

    // Break: line held low, one error, then idle three cycles after release
    begin
      exp_t e;
      e.is_end = 1'b0;
      e.data   = model_data;
      exp_q.push_back(e);
    end
    bus.rx = 1'b0;
    repeat (300) @(negedge clk);
    check("break_busy_held", {31'd0, bus.rx_busy}, 1);
    bus.rx = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.rx_busy && n < 20);
    check("break_release_latency", n, 3);
    drain();

    // Random traffic with occasional framing errors
    for (int k = 0; k < 24; k++) begin
      b  = 8'($urandom_range(0, 255));
      ok = ($urandom_range(0, 3) != 0);
      send_frame(b, ok);
      if (ok) idle($urandom_range(0, 12));
      else    idle($urandom_range(4, 12));
    end
    idle(20);
    drain();
    check("final_busy", {31'd0, bus.rx_busy}, 0);
    check("final_data", {24'd0, bus.rx_data}, {24'd0, model_data});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter: DIV_RATE, default 434, clk cycles per serial bit (50 MHz / 115200); legal range 4..65535.
REQ-002 Port: clk  input  1  system clock; all state changes on rising edge.
REQ-003 Port: reset  input  1  reset; synchronous, active-high.
REQ-004 Port: rx  input  1  asynchronous serial line; idle high; 8N1 frame, LSB first.
REQ-005 Port: rx_busy  output  1  high while a frame is being received (state != IDLE).
REQ-006 Port: rx_end  output  1  one-cycle pulse; valid frame received, rx_data updated the same cycle.
REQ-007 Port: rx_data  output  8  last correctly received byte; held until next valid frame.
REQ-008 Port: rx_ferr  output  1  one-cycle pulse; stop bit sampled low (framing error).

Function
REQ-009 rx SHALL pass through a 2-flop synchronizer; all logic uses synchronized rx_s only.
REQ-010 FSM states SHALL be IDLE, START, DATA, STOP, WAIT_HIGH; one bit-timer (16 bit) and one 3-bit bit counter.
REQ-011 IDLE: rx_s==0 -> START, timer cleared.
REQ-012 START: timer counts; at timer == DIV_RATE/2-1 (integer division) sample rx_s: 0 -> DATA, timer and bit counter cleared; 1 -> IDLE (glitch rejected, no pulse).
REQ-013 DATA: at timer == DIV_RATE-1 sample rx_s into internal shift register (LSB first: sample shifts in at MSB, register shifts right), timer cleared, bit counter +1; after 8th sample -> STOP.
REQ-014 STOP: at timer == DIV_RATE-1 sample rx_s: 1 -> rx_data <= shift register, rx_end pulse, -> IDLE; 0 -> rx_ferr pulse, rx_data unchanged, -> WAIT_HIGH.
REQ-015 rx_end and rx_ferr SHALL be registered, high exactly one cycle, asserted in the cycle after the stop-bit sample edge; never both high.
REQ-016 WAIT_HIGH: remain until rx_s==1, then -> IDLE; a held-low line (break) SHALL produce exactly one rx_ferr and no further frames.
REQ-017 rx_busy SHALL be high in START, DATA, STOP, WAIT_HIGH; low in IDLE; low in the rx_end cycle.
REQ-018 A new start bit SHALL be accepted in the first IDLE cycle after rx_end (back-to-back frames, no gap required beyond the stop bit).
REQ-019 Internal shift register SHALL never be visible on rx_data except via REQ-014.

Reset
REQ-020 reset SHALL force: state IDLE, timer 0, bit counter 0, shift register 0x00, rx_data 0x00, rx_end 0, rx_ferr 0, rx_busy 0, synchronizer flops 1.
REQ-021 reset asserted mid-frame SHALL abort the frame with no rx_end/rx_ferr pulse; after release the block waits for a fresh falling edge (a line still low mid-bit is treated as a start bit).

Verification
REQ-022 DIV_RATE=16, frame 0x55 (start, 1,0,1,0,1,0,1,0, stop) -> exactly one rx_end, rx_data==0x55, rx_ferr never high, rx_busy low after.
REQ-023 DIV_RATE=16, rx low for 4 cycles then high -> START aborts at half-bit, rx_busy high <=11 cycles, no rx_end/rx_ferr, rx_data unchanged.
REQ-024 DIV_RATE=16, frame 0xA3 with stop bit forced low, line then high -> one rx_ferr, rx_data keeps prior 0x55, FSM returns IDLE after line high.
REQ-025 DIV_RATE=16, bytes 0x00, 0xFF, 0x81 back-to-back with 1 stop bit each -> three rx_end pulses, rx_data sequence 0x00, 0xFF, 0x81.
REQ-026 DIV_RATE=16, reset pulsed during bit 4 of frame 0x3C, full 0xC3 frame follows after line idle -> no pulse for aborted frame, one rx_end with rx_data==0xC3.
REQ-027 DIV_RATE=16, rx held low 300 cycles (break) -> exactly one rx_ferr, rx_busy high until 3 cycles after line returns high.
